multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Moore control FSM that sequences the shared datapath of the multicycle RISC-V core: one ALU, one unified memory port, one register-file write port.
- Drives ALU operand muxes, write enables and the 2-bit alu_op consumed by the ALU decoder.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Adds a memory-ready handshake with a saturating wait counter and a sticky timeout flag.

Parameters:
- WAIT_CNT_W, default 4: width of the memory wait counter. The counter saturates at 2^WAIT_CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction/oldPC register enable
- result_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  SrcA: 00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  SrcB: 00=rs2, 01=Imm, 10=const 4
- alu_op  out  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- reg_write  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- mem_timeout  out  1  sticky: wait counter saturated
- illegal_op  out  1  trap indicator; tied 0 when the optional feature is disabled

Behaviour:
- State register is 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- rst_n low: state=FETCH immediately. Wait counter=0. mem_timeout=0. All enables (pc_write, ir_write, mem_write, reg_write) forced 0 while in reset. Reset mid-instruction aborts it with no further writes.
- Outputs decode from state only, plus zero and mem_ready where listed below. Any signal not listed for a state is 0.
- imm_src is combinational from op, independent of state: 0000011 and 0010011 give 00; 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; all others give 00.
- FETCH:
  - Outputs: alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, adr_src=0.
  - ir_write=pc_write=mem_ready.
  - Go to DECODE when mem_ready; otherwise stay.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target).
  - Next state by op: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BEQ; 1101111 to JAL.
  - Other opcodes: see Optional Feature.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. op=0000011 goes to MEMREAD; otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Go to MEMWB when mem_ready.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write is held until mem_ready, then instr_done=1 and go to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero, instr_done=1. Go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB, which writes PC+4 to rd.
- Latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4. Each wait cycle adds 1.
- Wait counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on any cycle with mem_ready=1 and in every other state.
  - Saturates at all-ones.
  - The cycle it reaches all-ones, mem_timeout sets; it stays set until reset.
  - The FSM keeps waiting; there is no abort.
- mem_ready in a non-waiting state is ignored.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unlisted opcode in DECODE goes to TRAP. TRAP holds all enables at 0 and illegal_op=1, and stays until rst_n asserts.
- Undefined: an unlisted opcode in DECODE goes to FETCH with instr_done=1 (NOP behaviour). There is no TRAP state and illegal_op is constant 0.

Test Plan:
- mem_ready tied 1, op=0110011 → states FETCH, DECODE, EXECR, ALUWB. EXECR alu_op=10; reg_write=1 only in cycle 4; instr_done pulses once.
- op=0000011, mem_ready low for 2 cycles in MEMREAD → 7 cycles total. reg_write and result_src=01 only in MEMWB. mem_timeout stays 0.
- op=1100011: zero=1 → pc_write=1 in BEQ with alu_op=01. zero=0 → pc_write=0. Both paths take 3 cycles.
- op=0100011 with mem_ready held 0 and WAIT_CNT_W=4 → mem_write stays 1. mem_timeout sets after 15 wait cycles and remains 1 after mem_ready rises and the FSM returns to FETCH.
- rst_n pulsed low during MEMWRITE → next cycle shows state FETCH, mem_write=0, counter=0, mem_timeout=0.
- op=1111111: with ILLEGAL_OP_TRAP_EN → illegal_op=1 and the FSM is stuck. Without it → back to FETCH, illegal_op=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle RISC-V datapath, with a memory-ready wait counter.
// Optional: define ILLEGAL_OP_TRAP_EN to trap unlisted opcodes in a TRAP state.
module multicycle_ctrl_fsm #(
  parameter int WAIT_CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       mem_timeout,
  output logic       illegal_op
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
    , TRAP   = 4'd11
`endif
  } state_t;

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  waiting;
  logic                  op_known;
  logic                  pc_write_d;
  logic                  mem_write_d;
  logic                  ir_write_d;
  logic                  reg_write_d;

  always_comb begin
    op_known = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_known = 1'b1;
      default:                                  op_known = 1'b0;
    endcase
  end

  assign waiting = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !mem_ready;

  // The FSM never aborts a stalled access; the counter only flags it via the sticky timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (waiting) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == CNT_MAX - 1'b1) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          if (!op_known) begin
`ifdef ILLEGAL_OP_TRAP_EN
            state <= TRAP;
`else
            state <= FETCH;
`endif
          end else begin
            case (op)
              OP_LW, OP_SW: state <= MEMADR;
              OP_R:         state <= EXECR;
              OP_I:         state <= EXECI;
              OP_BEQ:       state <= BEQ;
              OP_JAL:       state <= JAL;
              default:      state <= FETCH;
            endcase
          end
        end
        MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
        TRAP:     state <= TRAP;
`endif
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_d  = 1'b0;
    adr_src     = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    reg_write_d = 1'b0;
    instr_done  = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_d = mem_ready;
        pc_write_d = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
`ifndef ILLEGAL_OP_TRAP_EN
        instr_done = !op_known;
`endif
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src  = 2'b01;
        reg_write_d = 1'b1;
        instr_done  = 1'b1;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_d = 1'b1;
        instr_done  = mem_ready;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write_d = 1'b1;
        instr_done  = 1'b1;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write_d = zero;
        instr_done = 1'b1;
      end
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset returns state to FETCH at once, but FETCH would still enable on mem_ready; gate it.
  assign pc_write  = pc_write_d  & rst_n;
  assign mem_write = mem_write_d & rst_n;
  assign ir_write  = ir_write_d  & rst_n;
  assign reg_write = reg_write_d & rst_n;

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op = (state == TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm; expectations follow ILLEGAL_OP_TRAP_EN if defined.
module tb_multicycle_ctrl_fsm;

  typedef enum logic [3:0] {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_TRAP
  } t_state;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       instr_done;
  logic       mem_timeout;
  logic       illegal_op;

  logic [17:0] exp_q[$];
  logic        exp_tmo;
  int          vectors;
  int          miscompares;

  multicycle_ctrl_fsm #(.WAIT_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write),
    .instr_done(instr_done), .mem_timeout(mem_timeout), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector for a given state and the inputs present in that cycle.
  function automatic logic [17:0] exp_vec(input t_state s, input logic [6:0] o, input logic z,
                                          input logic r, input logic rn, input logic tmo);
    logic       pcw, adr, mw, irw, rw, dn, ill;
    logic [1:0] rs, sa, sb, ao, imm;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; dn = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; ao = 0;
    case (s)
      T_FETCH:    begin sb = 2; rs = 2; irw = r; pcw = r; end
      T_DECODE: begin
        sa = 1; sb = 1;
`ifndef ILLEGAL_OP_TRAP_EN
        dn = !(o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
`endif
      end
      T_MEMADR:   begin sa = 2; sb = 1; end
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin rs = 1; rw = 1; dn = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; dn = r; end
      T_EXECR:    begin sa = 2; ao = 2; end
      T_EXECI:    begin sa = 2; sb = 1; ao = 2; end
      T_ALUWB:    begin rw = 1; dn = 1; end
      T_BEQ:      begin sa = 2; ao = 1; pcw = z; dn = 1; end
      T_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      T_TRAP:     ill = 1;
      default: ;
    endcase
    case (o)
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
    if (!rn) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rs, sa, sb, ao, imm, rw, dn, tmo, ill};
  endfunction

  task automatic applyStimulus(input t_state s, input logic [6:0] o, input logic z,
                               input logic r, input logic rn);
    op = o; zero = z; mem_ready = r; rst_n = rn;
    exp_q.push_back(exp_vec(s, o, z, r, rn, exp_tmo));
  endtask

  task automatic checkOutput(input string tag);
    logic [17:0] obs;
    logic [17:0] exp;
    #1;
    obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           alu_op, imm_src, reg_write, instr_done, mem_timeout, illegal_op};
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input t_state s, input logic [6:0] o, input logic z, input logic r,
                      input logic rn, input string tag);
    @(negedge clk);
    applyStimulus(s, o, z, r, rn);
    checkOutput(tag);
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_tmo = 1'b0;
    rst_n = 1'b0; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    $display("[TB] multicycle_ctrl_fsm directed run starting");

    // Reset: enables held low even with mem_ready high in FETCH.
    step(T_FETCH, OP_R, 0, 1, 0, "reset_gate0");
    step(T_FETCH, OP_R, 0, 1, 0, "reset_gate1");
    step(T_FETCH, OP_R, 0, 0, 1, "fetch_wait");

    // R-type, mem_ready high.
    step(T_FETCH,  OP_R, 0, 1, 1, "r_fetch");
    step(T_DECODE, OP_R, 0, 1, 1, "r_decode");
    step(T_EXECR,  OP_R, 0, 1, 1, "r_execr");
    step(T_ALUWB,  OP_R, 0, 1, 1, "r_aluwb");

    // lw with two wait cycles in MEMREAD.
    step(T_FETCH,   OP_LW, 0, 1, 1, "lw_fetch");
    step(T_DECODE,  OP_LW, 0, 1, 1, "lw_decode");
    step(T_MEMADR,  OP_LW, 0, 1, 1, "lw_memadr");
    step(T_MEMREAD, OP_LW, 0, 0, 1, "lw_wait0");
    step(T_MEMREAD, OP_LW, 0, 0, 1, "lw_wait1");
    step(T_MEMREAD, OP_LW, 0, 1, 1, "lw_memread");
    step(T_MEMWB,   OP_LW, 0, 1, 1, "lw_memwb");

    // beq taken and not taken.
    step(T_FETCH,  OP_BEQ, 1, 1, 1, "beq1_fetch");
    step(T_DECODE, OP_BEQ, 1, 1, 1, "beq1_decode");
    step(T_BEQ,    OP_BEQ, 1, 1, 1, "beq1_taken");
    step(T_FETCH,  OP_BEQ, 0, 1, 1, "beq0_fetch");
    step(T_DECODE, OP_BEQ, 0, 1, 1, "beq0_decode");
    step(T_BEQ,    OP_BEQ, 0, 1, 1, "beq0_nottaken");

    // I-type and jal.
    step(T_FETCH,  OP_I, 0, 1, 1, "i_fetch");
    step(T_DECODE, OP_I, 0, 1, 1, "i_decode");
    step(T_EXECI,  OP_I, 0, 1, 1, "i_execi");
    step(T_ALUWB,  OP_I, 0, 1, 1, "i_aluwb");
    step(T_FETCH,  OP_JAL, 0, 1, 1, "jal_fetch");
    step(T_DECODE, OP_JAL, 0, 1, 1, "jal_decode");
    step(T_JAL,    OP_JAL, 0, 1, 1, "jal_jal");
    step(T_ALUWB,  OP_JAL, 0, 1, 1, "jal_aluwb");

    // sw stalled long enough to saturate the counter; timeout is sticky.
    step(T_FETCH,  OP_SW, 0, 1, 1, "sw_fetch");
    step(T_DECODE, OP_SW, 0, 1, 1, "sw_decode");
    step(T_MEMADR, OP_SW, 0, 1, 1, "sw_memadr");
    for (int i = 1; i <= 17; i++) begin
      exp_tmo = (i >= 16);
      step(T_MEMWRITE, OP_SW, 0, 0, 1, $sformatf("sw_wait%0d", i));
    end
    step(T_MEMWRITE, OP_SW, 0, 1, 1, "sw_done");
    step(T_FETCH,    OP_SW, 0, 1, 1, "sw_tmo_sticky");

    // Reset asserted mid-MEMWRITE aborts the store and clears the timeout.
    step(T_DECODE,   OP_SW, 0, 1, 1, "rst_decode");
    step(T_MEMADR,   OP_SW, 0, 1, 1, "rst_memadr");
    step(T_MEMWRITE, OP_SW, 0, 0, 1, "rst_memwrite");
    exp_tmo = 1'b0;
    step(T_FETCH,    OP_SW, 0, 1, 0, "rst_abort");
    step(T_FETCH,    OP_SW, 0, 1, 1, "rst_release");

    // Unlisted opcode.
    step(T_DECODE, OP_BAD, 0, 1, 1, "bad_decode");
`ifdef ILLEGAL_OP_TRAP_EN
    step(T_TRAP, OP_BAD, 0, 1, 1, "bad_trap0");
    step(T_TRAP, OP_R,   0, 1, 1, "bad_trap1");
    step(T_TRAP, OP_R,   0, 1, 1, "bad_trap2");
`else
    step(T_FETCH,  OP_R, 0, 1, 1, "bad_nop_fetch");
    step(T_DECODE, OP_R, 0, 1, 1, "bad_nop_decode");
`endif
    step(T_FETCH, OP_R, 0, 1, 0, "final_reset");
    step(T_FETCH, OP_R, 0, 1, 1, "final_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
